// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg
// Shared instruction-memory constants and loader state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DEPTH  = 64;
    localparam int INST_W      = 32;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_FINISH  = 2'd3
    } ld_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
//------------------------------------------------------------------------------
// byte_packer
// Big-endian 4-byte shift register with a 2-bit lane counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [INST_W-1:0] word,
    output logic              word_full
);

    logic [1:0]        r_lane;
    logic [INST_W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lane <= 2'd0;
            r_word <= '0;
        end else if (clear) begin
            r_lane <= 2'd0;
        end else if (shift_en) begin
            r_word <= {r_word[INST_W-9:0], byte_in};
            r_lane <= r_lane + 2'd1;
        end
    end

    // Flags the shift that completes a word, so the FSM can leave COLLECT on that same edge.
    assign word_full = shift_en && (r_lane == 2'd3);
    assign word      = r_word;

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
//------------------------------------------------------------------------------
// inst_mem_loader
// Packs a byte stream into 32-bit words and writes them to instruction memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_mem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [INST_W-1:0] checksum,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_cnt;
    logic [INST_W-1:0] r_checksum;

    logic [ADDR_W:0]   w_len_clamp;
    logic [ADDR_W:0]   w_cnt_next;
    logic              w_accept;
    logic              w_clear;
    logic              w_word_full;
    logic [INST_W-1:0] w_word;

    assign w_len_clamp = (load_len > c_depth) ? c_depth : load_len;
    assign w_cnt_next  = r_word_cnt + 1'b1;
    assign w_accept    = byte_valid && (r_state == LD_COLLECT);
    assign w_clear     = ((r_state == LD_IDLE) && start) || (r_state == LD_WRITE);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (w_accept),
        .clear     (w_clear),
        .byte_in   (byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_IDLE: begin
                if (start) begin
                    w_next = (w_len_clamp == '0) ? LD_FINISH : LD_COLLECT;
                end
            end
            LD_COLLECT: begin
                if (w_word_full) begin
                    w_next = LD_WRITE;
                end
            end
            LD_WRITE:  w_next = (w_cnt_next == r_len) ? LD_FINISH : LD_COLLECT;
            LD_FINISH: w_next = LD_IDLE;
            default:   w_next = LD_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        case (r_state)
            LD_COLLECT: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
            LD_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = r_word_cnt[ADDR_W-1:0];
                mem_wdata = w_word;
                cpu_hold  = 1'b1;
            end
            LD_FINISH: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Checksum and count survive FINISH so software can read them after the load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                LD_IDLE: begin
                    if (start) begin
                        r_len      <= w_len_clamp;
                        r_word_cnt <= '0;
                        r_checksum <= '0;
                    end
                end
                LD_WRITE: begin
                    r_word_cnt <= w_cnt_next;
                    r_checksum <= r_checksum ^ w_word;
                end
                default: ;
            endcase
        end
    end

    assign checksum = r_checksum;
    assign word_cnt = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
//------------------------------------------------------------------------------
// tb_inst_mem_loader
// Directed self-checking bench for the instruction memory loader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic [31:0] checksum;
    logic [6:0]  word_cnt;

    inst_mem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .checksum   (checksum),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back({26'd0, mem_addr});
            wd.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("byte_ready timeout", 32'(n), 32'd0);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk("done timeout", 32'(n), 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, " mem_we"},     32'(mem_we),     32'd0);
        chk({tag, " cpu_hold"},   32'(cpu_hold),   32'd0);
        chk({tag, " done"},       32'(done),       32'd0);
        chk({tag, " mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, " mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, " checksum"},   checksum,        32'd0);
        chk({tag, " word_cnt"},   32'(word_cnt),   32'd0);
    endtask

    typedef struct {
        logic [7:0]  b[4];
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int          base;
        logic [31:0] model_cs;
        logic [31:0] w;
        logic [7:0]  iv;
        logic [31:0] three[3];

        vecs[0].b = '{8'h3C, 8'h01, 8'h12, 8'h34}; vecs[0].exp = 32'h3C011234;
        vecs[1].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].exp = 32'hFFFFFFFF;
        vecs[2].b = '{8'hA5, 8'h5A, 8'h0F, 8'hF0}; vecs[2].exp = 32'hA55A0FF0;

        rst = 1'b0; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        tick(); tick();
        check_idle_zero("reset");
        rst = 1'b1;
        tick();

        // Single-word loads from the table
        for (int i = 0; i < 3; i++) begin
            wa.delete(); wd.delete();
            base = done_cnt;
            do_start(7'd1);
            chk("single cpu_hold after start", 32'(cpu_hold), 32'd1);
            chk("single byte_ready collect", 32'(byte_ready), 32'd1);
            for (int k = 0; k < 4; k++) send_byte(vecs[i].b[k], 0);
            chk("single mem_we after 4th byte", 32'(mem_we), 32'd1);
            chk("single byte_ready in write", 32'(byte_ready), 32'd0);
            wait_done(base);
            chk("single write count", 32'(wa.size()), 32'd1);
            if (wa.size() == 1) begin
                chk("single addr", wa[0], 32'd0);
                chk("single data", wd[0], vecs[i].exp);
            end
            chk("single checksum", checksum, vecs[i].exp);
            chk("single word_cnt", 32'(word_cnt), 32'd1);
            chk("single done once", 32'(done_cnt - base), 32'd1);
            chk("single cpu_hold drops", 32'(cpu_hold), 32'd0);
        end

        // Reset in the middle of a word, then a clean reload
        base = done_cnt;
        do_start(7'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rst = 1'b0;
        tick();
        check_idle_zero("midreset");
        rst = 1'b1;
        tick(); tick();
        chk("midreset no done", 32'(done_cnt - base), 32'd0);
        wa.delete(); wd.delete();
        base = done_cnt;
        do_start(7'd1);
        for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
        wait_done(base);
        chk("midreset write count", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("midreset addr", wa[0], 32'd0);
            chk("midreset data", wd[0], 32'h00000000);
        end

        // Three words with byte_valid only every third cycle
        three = '{32'h20080005, 32'h20090003, 32'h01095020};
        wa.delete(); wd.delete();
        base = done_cnt;
        do_start(7'd3);
        for (int j = 0; j < 3; j++) begin
            w = three[j];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 2);
        end
        wait_done(base);
        chk("three write count", 32'(wa.size()), 32'd3);
        for (int j = 0; j < 3 && j < wa.size(); j++) begin
            chk("three addr", wa[j], 32'(j));
            chk("three data", wd[j], three[j]);
        end
        chk("three checksum", checksum, 32'h01085026);
        chk("three word_cnt", 32'(word_cnt), 32'd3);

        // Zero-length load
        wa.delete(); wd.delete();
        base = done_cnt;
        do_start(7'd0);
        chk("len0 done", 32'(done), 32'd1);
        chk("len0 byte_ready", 32'(byte_ready), 32'd0);
        chk("len0 checksum", checksum, 32'd0);
        chk("len0 word_cnt", 32'(word_cnt), 32'd0);
        tick();
        chk("len0 done pulse ends", 32'(done), 32'd0);
        chk("len0 cpu_hold drops", 32'(cpu_hold), 32'd0);
        chk("len0 no writes", 32'(wa.size()), 32'd0);
        chk("len0 done once", 32'(done_cnt - base), 32'd1);

        // Oversized length is clamped to the memory depth
        wa.delete(); wd.delete();
        base = done_cnt;
        model_cs = '0;
        do_start(7'd100);
        for (int j = 0; j < 64; j++) begin
            iv = 8'(j);
            w = {iv, 8'hA5 ^ iv, 8'h3C, ~iv};
            model_cs = model_cs ^ w;
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 0);
        end
        wait_done(base);
        chk("clamp write count", 32'(wa.size()), 32'd64);
        if (wa.size() == 64) begin
            chk("clamp last addr", wa[63], 32'd63);
            iv = 8'd63;
            chk("clamp last data", wd[63], {iv, 8'hA5 ^ iv, 8'h3C, ~iv});
            iv = 8'd17;
            chk("clamp mid data", wd[17], {iv, 8'hA5 ^ iv, 8'h3C, ~iv});
        end
        chk("clamp checksum", checksum, model_cs);
        chk("clamp word_cnt", 32'(word_cnt), 32'd64);

        // Second start during COLLECT, byte held through WRITE
        wa.delete(); wd.delete();
        base = done_cnt;
        do_start(7'd2);
        send_byte(8'h11, 0);
        start = 1'b1; load_len = 7'd7;
        tick();
        start = 1'b0;
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        chk("held mem_we", 32'(mem_we), 32'd1);
        chk("held byte_ready in write", 32'(byte_ready), 32'd0);
        byte_valid = 1'b1; byte_data = 8'h55;
        tick();
        chk("held byte_ready back", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        wait_done(base);
        chk("held write count", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("held data0", wd[0], 32'h11223344);
            chk("held data1", wd[1], 32'h55667788);
            chk("held addr1", wa[1], 32'd1);
        end
        chk("held word_cnt", 32'(word_cnt), 32'd2);
        chk("held checksum", checksum, 32'h444444CC);
        tick(); tick();
        chk("held no extra done", 32'(done_cnt - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart of the instruction fetch path.
- Receives a byte stream (e.g. from a UART receiver), packs it big-endian into 32-bit MIPS instruction words, and writes them sequentially into the instruction memory from word address 0.
- Holds the CPU in reset while a load is in progress, so fetch only ever sees a complete program.

Parameters:
- ADDR_W, 6, word-address width of instruction memory. Matches a 64-word memory indexed by PC[7:2].
- DEPTH, 64, number of words in instruction memory. Must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when IDLE.
- load_len  in  ADDR_W+1  number of words to load; sampled on an accepted start.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  word write address.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  high while a load is active; drives the CPU/PC reset.
- done  out  1  one-cycle pulse when a load completes.
- checksum  out  32  XOR of all words written in the last load.
- word_cnt  out  ADDR_W+1  words written so far in the current or last load.

Behaviour:
- Reset (rst==0 at clk edge):
  - State goes to IDLE.
  - byte_ready, mem_we, cpu_hold and done are 0.
  - mem_addr, mem_wdata, checksum and word_cnt are 0.
  - Byte lane counter is 0.
  - Reset during a load abandons it: no done pulse, and the partial word is discarded.
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - byte_ready=0 and cpu_hold=0.
  - On start=1:
    - latch len = min(load_len, DEPTH);
    - clear checksum, word_cnt and the lane counter.
  - If len==0, go to FINISH; otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1 and cpu_hold=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Accepted bytes shift in MSB-first: word = {word[23:0], byte_data}. The first byte received becomes bits [31:24].
  - On the 4th accepted byte, go to WRITE on the next edge.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_addr=word_cnt[ADDR_W-1:0], mem_wdata=assembled word.
  - At the edge: checksum ^= word, word_cnt += 1, lane counter = 0.
  - Next state is FINISH if word_cnt+1 == len, otherwise COLLECT.
- FINISH (one cycle):
  - done=1 and cpu_hold=1, then go to IDLE.
  - cpu_hold drops the cycle after done.
- Latency:
  - The 4th byte accepted at edge N gives mem_we high in cycle N+1.
  - Minimum spacing is 5 cycles per word (4 byte cycles plus 1 write cycle).
- start while not IDLE is ignored.
- byte_valid in IDLE, WRITE or FINISH is not accepted (byte_ready=0); the source must hold the byte.
- Clamping: load_len > DEPTH is clamped to DEPTH, so addresses never wrap past DEPTH-1.
- mem_we is never asserted outside WRITE.
- checksum and word_cnt hold their values after FINISH until the next accepted start.

Decomposition:
- Shared package mips_pkg holds:
  - the state enum LD_IDLE, LD_COLLECT, LD_WRITE, LD_FINISH;
  - the constants IMEM_ADDR_W=6, IMEM_DEPTH=64, INST_W=32.
- One sub-module, byte_packer:
  - 4-lane shift register plus 2-bit lane counter;
  - inputs: shift enable and clear;
  - outputs: word and word_full.
- The top level contains the FSM, the address/word counter and the checksum.

Test Plan:
- Reset mid-load: rst=0 after 2 bytes of word 1.
  - Required: all outputs 0, state IDLE, no done.
  - A following start with load_len=1 and bytes 00,00,00,00 writes addr0=0x00000000.
- Single word: start, load_len=1, bytes 3C,01,12,34.
  - Required: one mem_we cycle with addr 0, wdata 0x3C011234.
  - done one cycle later; checksum=0x3C011234; word_cnt=1; cpu_hold high from the cycle after start through done.
- Three words with byte_valid gaps (valid every 3rd cycle): words 0x20080005, 0x20090003, 0x01095020.
  - Required: writes to addr 0,1,2 in order; checksum = XOR of the three words; no extra mem_we.
- load_len=0.
  - Required: done pulses on the cycle after start; no mem_we; byte_ready stays 0; checksum=0.
- load_len=100.
  - Required: clamped to 64; last write at addr 63; done after the 64th word; word_cnt=64.
- start pulsed again during COLLECT, plus byte_valid held during WRITE.
  - Required: the second start is ignored.
  - The held byte is accepted only in the next COLLECT cycle.
  - The word sequence is unchanged.
